exu_lsu: RTL

- Load/store unit for the RV32I execute stage. Sits directly downstream of the ALU and consumes its adder output as the effective address.
- Issues one word-aligned request to the data-memory bus using a valid/ready request and a response-valid handshake.
- Returns aligned, sign- or zero-extended load data to writeback.
- Raises exceptions for misaligned accesses, illegal funct3 values and bus timeouts. The core stalls while lsu_o_ready is low.

---
 rtl/exu_lsu_pkg.sv | 42 ++++
 rtl/exu_lsu_if.sv | 21 ++
 rtl/exu_lsu_align.sv | 48 ++++
 rtl/exu_lsu.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/exu_lsu_pkg.sv
// Shared encodings for the RV32I load/store unit: funct3 codes, exception causes,
// FSM states and the latched-op record.
package exu_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      CAUSE_LD_MISALIGN  = 2'd0,
      CAUSE_ST_MISALIGN  = 2'd1,
      CAUSE_ACCESS_FAULT = 2'd2,
      CAUSE_ILLEGAL      = 2'd3
   } exc_cause_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } lsu_state_e;

   typedef struct packed {
      logic       store;
      logic [2:0] funct3;
      logic [1:0] addr_lo;
      logic [4:0] rd;
   } lsu_op_t;

   function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
      if (store) return (f3 > F3_W);
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   // Low two funct3 bits give the access size for both loads and stores.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/exu_lsu_if.sv
// Data-memory bus: valid/ready request channel plus a response-valid return.
interface exu_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        rsp_valid;
   logic [31:0] rsp_data;

   modport master (
      output req_valid, addr, we, wstrb, wdata,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, addr, we, wstrb, wdata,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/exu_lsu_align.sv
// Byte-lane steering: store data replication and strobes, load extract and extend.
module lsu_align
   import exu_lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_data,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_wstrb,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] rsp_data,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      st_wdata = st_data;
      st_wstrb = 4'b0000;
      case (st_funct3)
         F3_B: begin
            st_wdata = {4{st_data[7:0]}};
            st_wstrb = 4'b0001 << st_addr_lo;
         end
         F3_H: begin
            st_wdata = {2{st_data[15:0]}};
            st_wstrb = st_addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         F3_W:    st_wstrb = 4'b1111;
         default: ;
      endcase
   end

   assign shifted = rsp_data >> {ld_addr_lo, 3'b000};

   always_comb begin
      ld_data = shifted;
      case (ld_funct3)
         F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   ld_data = {24'd0, shifted[7:0]};
         F3_HU:   ld_data = {16'd0, shifted[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/exu_lsu.sv
// RV32I load/store unit: accepts one op from execute, runs a single bus transaction
// with a timeout, and returns extended load data or an exception pulse.
module exu_lsu
   import exu_lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_EN     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lsu_i_valid,
   output logic        lsu_o_ready,
   input  logic        lsu_i_store,
   input  logic [2:0]  lsu_i_funct3,
   input  logic [31:0] lsu_i_addr,
   input  logic [31:0] lsu_i_wdata,
   input  logic [4:0]  lsu_i_rd,
   exu_lsu_if.master   mem,
   output logic        lsu_o_wb_valid,
   output logic [4:0]  lsu_o_wb_rd,
   output logic [31:0] lsu_o_wb_data,
   output logic        lsu_o_done,
   output logic        lsu_o_exc,
   output logic [1:0]  lsu_o_exc_cause
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_e  state;
   lsu_op_t     op;
   logic [CW-1:0] cnt;
   logic [CW:0]   cnt_nxt;
   logic        timeout;
   exc_cause_e  cause_q;

   logic        req_valid_q;
   logic [31:0] addr_q;
   logic        we_q;
   logic [3:0]  wstrb_q;
   logic [31:0] wdata_q;

   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [31:0] ld_data;
   logic        op_illegal;
   logic        op_misaligned;

   // Store lanes are formed from the live inputs at accept; load formatting uses the latched op.
   lsu_align u_align (
      .st_funct3  (lsu_i_funct3),
      .st_addr_lo (lsu_i_addr[1:0]),
      .st_data    (lsu_i_wdata),
      .st_wdata   (st_wdata),
      .st_wstrb   (st_wstrb),
      .ld_funct3  (op.funct3),
      .ld_addr_lo (op.addr_lo),
      .rsp_data   (mem.rsp_data),
      .ld_data    (ld_data)
   );

   assign op_illegal    = f3_illegal(lsu_i_store, lsu_i_funct3);
   assign op_misaligned = misaligned(lsu_i_funct3, lsu_i_addr[1:0]);

   // Fires on the cycle the count would reach TIMEOUT_CYCLES-1.
   assign cnt_nxt = {1'b0, cnt} + 1'b1;
   assign timeout = (TIMEOUT_EN != 0) && (cnt_nxt >= (CW+1)'(TIMEOUT_CYCLES - 1));

   assign lsu_o_ready     = (state == S_IDLE);
   assign lsu_o_exc_cause = cause_q;

   assign mem.req_valid = req_valid_q;
   assign mem.addr      = addr_q;
   assign mem.we        = we_q;
   assign mem.wstrb     = wstrb_q;
   assign mem.wdata     = wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         op             <= '0;
         cnt            <= '0;
         cause_q        <= CAUSE_LD_MISALIGN;
         req_valid_q    <= 1'b0;
         addr_q         <= '0;
         we_q           <= 1'b0;
         wstrb_q        <= '0;
         wdata_q        <= '0;
         lsu_o_wb_valid <= 1'b0;
         lsu_o_wb_rd    <= '0;
         lsu_o_wb_data  <= '0;
         lsu_o_done     <= 1'b0;
         lsu_o_exc      <= 1'b0;
      end else begin
         lsu_o_wb_valid <= 1'b0;
         lsu_o_done     <= 1'b0;
         lsu_o_exc      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (lsu_i_valid) begin
                  op  <= '{store: lsu_i_store, funct3: lsu_i_funct3,
                           addr_lo: lsu_i_addr[1:0], rd: lsu_i_rd};
                  cnt <= '0;
                  if (op_illegal) begin
                     lsu_o_exc <= 1'b1;
                     cause_q   <= CAUSE_ILLEGAL;
                  end else if (op_misaligned) begin
                     lsu_o_exc <= 1'b1;
                     cause_q   <= lsu_i_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                  end else begin
                     state       <= S_REQ;
                     req_valid_q <= 1'b1;
                     addr_q      <= {lsu_i_addr[31:2], 2'b00};
                     we_q        <= lsu_i_store;
                     wstrb_q     <= lsu_i_store ? st_wstrb : 4'b0000;
                     wdata_q     <= lsu_i_store ? st_wdata : 32'd0;
                  end
               end
            end
            S_REQ: begin
               if (timeout) begin
                  state       <= S_IDLE;
                  req_valid_q <= 1'b0;
                  lsu_o_exc   <= 1'b1;
                  cause_q     <= CAUSE_ACCESS_FAULT;
               end else begin
                  cnt <= cnt_nxt[CW-1:0];
                  if (mem.req_ready) begin
                     state       <= S_WAIT;
                     req_valid_q <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               // A response landing on the timeout cycle still completes the op.
               if (mem.rsp_valid) begin
                  state      <= S_DONE;
                  lsu_o_done <= 1'b1;
                  if (!op.store) begin
                     lsu_o_wb_valid <= 1'b1;
                     lsu_o_wb_rd    <= op.rd;
                     lsu_o_wb_data  <= ld_data;
                  end
               end else if (timeout) begin
                  state     <= S_IDLE;
                  lsu_o_exc <= 1'b1;
                  cause_q   <= CAUSE_ACCESS_FAULT;
               end else begin
                  cnt <= cnt_nxt[CW-1:0];
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
